// File: rtl/cipher_cfg_pkg.sv
// rtl/cipher_cfg_pkg.sv - shared FSM states and size constants for the cipher config streamer
// No ports. Exports default ROUND/SBOX_WIDTH/KEY_SIZE, the table depth and the FSM state type.
package cipher_cfg_pkg;

  localparam int DEF_ROUND      = 5;
  localparam int DEF_SBOX_WIDTH = 8;
  localparam int DEF_KEY_SIZE   = 128;

  function automatic int table_depth(input int width);
    return 2 ** width;
  endfunction

  localparam int TABLE_DEPTH = table_depth(DEF_SBOX_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SBOX,
    GAP,
    KEY,
    DONE
  } state_t;

endpackage

// File: rtl/cfg_sbox_ram.sv
// rtl/cfg_sbox_ram.sv - S-box table storage, one write port and one registered read port
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata registered read data.
module cfg_sbox_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write-first: a write landing on the address being read shows up in rdata
  // on the same edge, so a write issued together with start is streamed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/cipher_cfg_streamer.sv
// rtl/cipher_cfg_streamer.sv - streams an S-box table then round keys to cipher cores
// Optional feature macro: CFG_SBOX_PERM_CHECK_EN (S-box permutation check before streaming).
// Ports: clk, reset_n (async active-low); sbox_we/sbox_waddr/sbox_wdata and
// key_we/key_waddr/key_wdata host writes (IDLE only); start stream request;
// sbox_valid/sbox_out table beats; key_tvalid/key round-key beats;
// busy (not IDLE), done (one-cycle completion), cfg_err (sticky permutation failure).
module cipher_cfg_streamer
  import cipher_cfg_pkg::*;
#(
  parameter int ROUND      = DEF_ROUND,
  parameter int SBOX_WIDTH = DEF_SBOX_WIDTH,
  parameter int KEY_SIZE   = DEF_KEY_SIZE
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     sbox_we,
  input  logic [SBOX_WIDTH-1:0]                    sbox_waddr,
  input  logic [SBOX_WIDTH-1:0]                    sbox_wdata,
  input  logic                                     key_we,
  input  logic [((ROUND > 1) ? $clog2(ROUND) : 1)-1:0] key_waddr,
  input  logic [KEY_SIZE-1:0]                      key_wdata,
  input  logic                                     start,
  output logic                                     sbox_valid,
  output logic [SBOX_WIDTH-1:0]                    sbox_out,
  output logic                                     key_tvalid,
  output logic [KEY_SIZE-1:0]                      key,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     cfg_err
);

  localparam int KAW   = (ROUND > 1) ? $clog2(ROUND) : 1;
  localparam int DEPTH = table_depth(SBOX_WIDTH);

  localparam logic [SBOX_WIDTH-1:0] SLAST  = SBOX_WIDTH'(DEPTH - 1);
  localparam logic [KAW-1:0]        KLAST  = KAW'(ROUND - 1);
  localparam logic [KAW:0]          KLIMIT = (KAW + 1)'(ROUND);

  state_t                state, state_nx;
  logic [SBOX_WIDTH-1:0] cnt, cnt_nx;
  logic [KAW-1:0]        kcnt, kcnt_nx;
  logic [SBOX_WIDTH-1:0] raddr;
  logic [SBOX_WIDTH-1:0] rdata;
  logic                  idle;
  logic                  accept;
  logic [KEY_SIZE-1:0]   keys [ROUND];

  assign idle   = (state == IDLE);
  assign accept = idle && start;

  cfg_sbox_ram #(
    .AW(SBOX_WIDTH),
    .DW(SBOX_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (sbox_we && idle),
    .waddr(sbox_waddr),
    .wdata(sbox_wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Out-of-range key indices are silently dropped.
  always_ff @(posedge clk) begin
    if (key_we && idle && ({1'b0, key_waddr} < KLIMIT)) begin
      keys[key_waddr] <= key_wdata;
    end
  end

`ifdef CFG_SBOX_PERM_CHECK_EN
  logic [DEPTH-1:0] seen;
  logic             dup;
  logic             err;
  logic             hit;

  assign hit = seen[rdata];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen <= '0;
      dup  <= 1'b0;
      err  <= 1'b0;
    end else if (accept) begin
      seen <= '0;
      dup  <= 1'b0;
      err  <= 1'b0;
    end else if (state == CHECK) begin
      seen[rdata] <= 1'b1;
      if (hit) begin
        dup <= 1'b1;
      end
      if ((cnt == SLAST) && (dup || hit)) begin
        err <= 1'b1;
      end
    end
  end

  assign cfg_err = err;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      kcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      kcnt  <= kcnt_nx;
    end
  end

  // The RAM read is registered, so raddr always points at the entry needed
  // on the following cycle; in IDLE it parks at 0 for the first beat.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    kcnt_nx  = kcnt;
    raddr    = cnt + 1'b1;
    case (state)
      IDLE: begin
        raddr   = '0;
        cnt_nx  = '0;
        kcnt_nx = '0;
        if (start) begin
`ifdef CFG_SBOX_PERM_CHECK_EN
          state_nx = CHECK;
`else
          state_nx = SBOX;
`endif
        end
      end
`ifdef CFG_SBOX_PERM_CHECK_EN
      CHECK: begin
        if (cnt == SLAST) begin
          raddr    = '0;
          cnt_nx   = '0;
          state_nx = (dup || hit) ? IDLE : SBOX;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`endif
      SBOX: begin
        if (cnt == SLAST) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        kcnt_nx  = '0;
        state_nx = KEY;
      end
      KEY: begin
        if (kcnt == KLAST) begin
          kcnt_nx  = '0;
          state_nx = DONE;
        end else begin
          kcnt_nx = kcnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign sbox_valid = (state == SBOX);
  assign sbox_out   = sbox_valid ? rdata : '0;
  assign key_tvalid = (state == KEY);
  assign key        = key_tvalid ? keys[kcnt] : '0;
  assign busy       = !idle;
  assign done       = (state == DONE);

endmodule
